// File: rtl/dmem_bus_arbiter.sv
// Arbitrates fetch and MEM-stage requests onto one SRAM-like bus, one transaction in flight.
// Optional ARB_RR_EN: round-robin tie breaking; undefined gives fixed priority (data first).
module dmem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_ben,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [DATA_W/8-1:0] bus_ben,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_t;

  state_t state_q, state_d;
  owner_t owner_q;
  logic   data_legal;
  logic   pick_data;
  logic   pick_inst;
  logic   grant;

  // An all-zero byte enable marks an illegal access; the MEM stage traps it instead.
  assign data_legal = data_req && (data_ben != '0);

`ifdef ARB_RR_EN
  owner_t last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     last_q <= OWN_INST;
    else if (grant) last_q <= pick_data ? OWN_DATA : OWN_INST;
  end

  assign pick_data = data_legal && (!inst_req || (last_q == OWN_INST));
`else
  assign pick_data = data_legal;
`endif

  assign pick_inst = inst_req && !pick_data;
  assign grant     = (state_q == S_IDLE) && (pick_data || pick_inst);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first, so no path leaves state_d unassigned and no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant)       state_d = S_ADDR;
      S_ADDR:  if (bus_addr_ok) state_d = S_DATA;
      S_DATA:  if (bus_data_ok) state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // Payload is captured once at grant and held until the next grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q   <= OWN_NONE;
      bus_wr    <= 1'b0;
      bus_ben   <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else if (grant) begin
      owner_q   <= pick_data ? OWN_DATA : OWN_INST;
      bus_wr    <= pick_data ? data_wr : 1'b0;
      bus_ben   <= pick_data ? data_ben : '1;
      bus_addr  <= pick_data ? data_addr : inst_addr;
      bus_wdata <= pick_data ? data_wdata : '0;
    end else if ((state_q == S_DATA) && bus_data_ok) begin
      owner_q   <= OWN_NONE;
    end
  end

  always_comb begin
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    bus_req      = (state_q == S_ADDR);
    busy         = (state_q != S_IDLE);
    // Bus handshakes outside their own phase are protocol errors and never forwarded.
    if ((state_q == S_ADDR) && bus_addr_ok) begin
      inst_addr_ok = (owner_q == OWN_INST);
      data_addr_ok = (owner_q == OWN_DATA);
    end
    if ((state_q == S_DATA) && bus_data_ok) begin
      inst_data_ok = (owner_q == OWN_INST);
      data_data_ok = (owner_q == OWN_DATA);
    end
  end

  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

endmodule
